// File: rtl/pieton_cerere.sv
// Pedestrian request unit: debounced push-button request, grant handshake, crossing countdown.
// Optional acoustic signal built only when PIETON_SUNET_EN is defined.
module pieton_cerere #(
    parameter int CLK_DIV   = 1000000,
    parameter int DEB_CYC   = 20000,
    parameter int T_TRAV    = 30,
    parameter int BLINK_SEC = 5,
    parameter int WIDTH     = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             buton_raw,
    input  logic             acord,
    output logic             cerere,
    output logic             asteptare,
    output logic             verde_p_out,
    output logic             rosu_p_out,
    output logic [WIDTH-1:0] secunde_ramase,
    output logic             sunet
);
    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int DW = $clog2(DEB_CYC + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WAIT  = 2'd1;
    localparam logic [1:0] S_CROSS = 2'd2;
    localparam logic [1:0] S_CLEAR = 2'd3;

    localparam logic [WIDTH-1:0] BLINK_W = WIDTH'(BLINK_SEC);
    localparam logic [WIDTH-1:0] TRAV_W  = WIDTH'(T_TRAV);

    logic          sync1, sync2, buton_deb, buton_deb_q, acord_q;
    logic [DW-1:0] deb_cnt;
    logic [PW-1:0] pre;
    logic [WIDTH-1:0] sec;
    logic [1:0]    state, state_nxt;
    logic          press, acord_rise, acord_fall, tick, half, enter_cross, in_cross;

    assign press       = buton_deb & ~buton_deb_q;
    assign acord_rise  = acord & ~acord_q;
    assign acord_fall  = ~acord & acord_q;
    assign tick        = (pre == PW'(CLK_DIV - 1));
    assign half        = (pre >= PW'(CLK_DIV / 2));
    assign in_cross    = (state == S_CROSS);
    assign enter_cross = (state_nxt == S_CROSS) && !in_cross;

    // Debounce: accept a new level only after it has been stable for DEB_CYC cycles
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1       <= 1'b0;
            sync2       <= 1'b0;
            buton_deb   <= 1'b0;
            buton_deb_q <= 1'b0;
            deb_cnt     <= '0;
            acord_q     <= 1'b0;
        end else begin
            sync1       <= buton_raw;
            sync2       <= sync1;
            buton_deb_q <= buton_deb;
            acord_q     <= acord;
            if (sync2 != buton_deb) begin
                if (deb_cnt == DW'(DEB_CYC - 1)) begin
                    buton_deb <= sync2;
                    deb_cnt   <= '0;
                end else begin
                    deb_cnt <= deb_cnt + 1'b1;
                end
            end else begin
                deb_cnt <= '0;
            end
        end
    end

    // Prescaler restarts on crossing entry so the first second is full length
    always_ff @(posedge clk) begin
        if (rst || enter_cross || tick) pre <= '0;
        else                            pre <= pre + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst)                                sec <= '0;
        else if (enter_cross)                   sec <= TRAV_W;
        else if (in_cross && tick && sec != '0) sec <= sec - 1'b1;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (acord_rise) state_nxt = S_CROSS;
                     else if (press) state_nxt = S_WAIT;
            S_WAIT:  if (acord_rise) state_nxt = S_CROSS;
            S_CROSS: if (acord_fall) state_nxt = S_CLEAR;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        cerere         = (state == S_WAIT);
        asteptare      = (state == S_WAIT);
        secunde_ramase = in_cross ? sec : '0;
        rosu_p_out     = !(in_cross && sec != '0);
        verde_p_out    = 1'b0;
        if (in_cross) begin
            if (sec > BLINK_W)   verde_p_out = 1'b1;
            else if (sec != '0)  verde_p_out = ~half;
        end
    end

`ifdef PIETON_SUNET_EN
    // Eighth-of-second index; its LSB gives a 4 Hz square wave
    logic [PW+2:0] eighth;
    assign eighth = {pre, 3'b000} / (PW+3)'(CLK_DIV);

    always_comb begin
        sunet = 1'b0;
        if (in_cross) begin
            if (sec > BLINK_W)  sunet = ~half;
            else if (sec != '0) sunet = ~eighth[0];
        end
    end
`else
    assign sunet = 1'b0;
`endif

endmodule

// File: tb/tb_pieton_cerere.sv
// Directed bench for pieton_cerere with small timing parameters (10-cycle second).
module tb_pieton_cerere;
    logic       clk = 1'b0;
    logic       rst, buton_raw, acord;
    logic       cerere, asteptare, verde_p_out, rosu_p_out, sunet;
    logic [5:0] secunde_ramase;

    int vectors = 0;
    int miscompares = 0;

`ifdef PIETON_SUNET_EN
    localparam bit SUN = 1'b1;
`else
    localparam bit SUN = 1'b0;
`endif

    pieton_cerere #(.CLK_DIV(10), .DEB_CYC(4), .T_TRAV(6), .BLINK_SEC(2), .WIDTH(6)) dut (
        .clk(clk), .rst(rst), .buton_raw(buton_raw), .acord(acord),
        .cerere(cerere), .asteptare(asteptare), .verde_p_out(verde_p_out),
        .rosu_p_out(rosu_p_out), .secunde_ramase(secunde_ramase), .sunet(sunet)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    // Advance n rising edges, then settle 1 time unit past the edge
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input int c, input int v, input int r, input int s);
        chk({tag, ".cerere"}, int'(cerere), c);
        chk({tag, ".asteptare"}, int'(asteptare), c);
        chk({tag, ".verde"}, int'(verde_p_out), v);
        chk({tag, ".rosu"}, int'(rosu_p_out), r);
        chk({tag, ".sec"}, int'(secunde_ramase), s);
    endtask

    initial begin
        rst = 1'b1; buton_raw = 1'b1; acord = 1'b0;
        step(2);
        chk_out("reset", 0, 0, 1, 0);
        chk("reset.sunet", int'(sunet), 0);

        // Press held through reset: accepted 2+4 cycles after release, WAIT one edge later
        rst = 1'b0;
        step(6);
        chk("lat6.cerere", int'(cerere), 0);
        step(1);
        chk_out("lat7", 1, 0, 1, 0);
        chk("wait.sunet", int'(sunet), 0);

        // Mid-operation reset
        rst = 1'b1; buton_raw = 1'b0;
        step(1);
        chk_out("midrst", 0, 0, 1, 0);
        rst = 1'b0;
        step(3);

        // Bounce every 2 cycles never reaches the debounce count
        for (int i = 0; i < 10; i++) begin
            buton_raw = ~buton_raw;
            step(2);
        end
        buton_raw = 1'b0;
        step(8);
        chk("bounce.cerere", int'(cerere), 0);
        buton_raw = 1'b1;
        step(6);
        chk("bounce6.cerere", int'(cerere), 0);
        step(1);
        chk_out("bounce7", 1, 0, 1, 0);

        // Grant handshake and countdown
        acord = 1'b1;
        step(1);
        chk_out("cross0", 0, 1, 0, 6);
        chk("cross0.sunet", int'(sunet), int'(SUN));
        step(9);
        chk("cross9.sec", int'(secunde_ramase), 6);
        step(1);
        chk_out("cross10", 0, 1, 0, 5);
        chk("cross10.sunet", int'(sunet), int'(SUN));
        step(5);
        chk("cross15.sunet", int'(sunet), 0);
        chk("cross15.verde", int'(verde_p_out), 1);
        step(25);
        chk_out("cross40", 0, 1, 0, 2);
        chk("cross40.sunet", int'(sunet), int'(SUN));
        step(2);
        chk("cross42.sunet", int'(sunet), 0);
        step(2);
        chk("cross44.verde", int'(verde_p_out), 1);
        step(1);
        chk("cross45.verde", int'(verde_p_out), 0);
        step(4);
        chk("cross49.verde", int'(verde_p_out), 0);
        step(1);
        chk_out("cross50", 0, 1, 0, 1);

        // Exhaustion: saturate at 0, hold red while grant stays high
        step(10);
        chk_out("cross60", 0, 0, 1, 0);
        chk("cross60.sunet", int'(sunet), 0);
        step(20);
        chk_out("cross80", 0, 0, 1, 0);
        acord = 1'b0;
        step(1);
        chk_out("clear", 0, 0, 1, 0);
        chk("clear.sunet", int'(sunet), 0);
        step(1);
        chk_out("idle", 0, 0, 1, 0);

        // Unsolicited grant from IDLE, press during CROSS, early grant removal
        buton_raw = 1'b0;
        step(8);
        acord = 1'b1;
        step(1);
        chk_out("ucross0", 0, 1, 0, 6);
        step(20);
        chk("ucross20.sec", int'(secunde_ramase), 4);
        buton_raw = 1'b1;
        step(7);
        chk_out("ucross27", 0, 1, 0, 4);
        acord = 1'b0;
        step(1);
        chk_out("uclear", 0, 0, 1, 0);
        step(1);
        chk_out("uidle", 0, 0, 1, 0);
        step(3);
        chk("uidle3.cerere", int'(cerere), 0);

        // Grant already high when reset is released
        rst = 1'b1; acord = 1'b1; buton_raw = 1'b0;
        step(2);
        chk_out("rstacord", 0, 0, 1, 0);
        rst = 1'b0;
        step(1);
        chk_out("rstacord.cross", 0, 1, 0, 6);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
